// File: rtl/param_mux_pkg.sv
// Shared definitions for the param_mux family: sequencer state and select-width helper.
package param_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A one-input mux still needs a 1-bit select port.
  function automatic int sel_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/param_mux_seq.sv
// Word sequencer that drives param_mux data/select so its output becomes a bit stream.
// Build option: PARAM_MUX_SEQ_MSB_FIRST_EN selects MSB-first order (default LSB-first).
module param_mux_seq
  import param_mux_pkg::*;
#(
  parameter int  IP_WIDTH  = 8,
  localparam int SEL_WIDTH = sel_width(IP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IP_WIDTH-1:0]  in_data,
  output logic [IP_WIDTH-1:0]  mux_i,
  output logic [SEL_WIDTH-1:0] mux_s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [SEL_WIDTH-1:0] POS_MAX = SEL_WIDTH'(IP_WIDTH - 1);

`ifdef PARAM_MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_WIDTH-1:0] FIRST_POS = POS_MAX;
  localparam logic [SEL_WIDTH-1:0] LAST_POS  = '0;
`else
  localparam logic [SEL_WIDTH-1:0] FIRST_POS = '0;
  localparam logic [SEL_WIDTH-1:0] LAST_POS  = POS_MAX;
`endif

  state_e               state_q;
  logic [IP_WIDTH-1:0]  word_q;
  logic [SEL_WIDTH-1:0] pos_q;
  logic [SEL_WIDTH-1:0] pos_d;
  logic                 out_fire;
  logic                 in_fire;

  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;
  assign out_last  = out_valid && (pos_q == LAST_POS);
  assign out_fire  = out_valid && out_ready;
  // Ready opens on the final beat so the next word loads with no bubble.
  assign in_ready  = (state_q == IDLE) || (out_fire && out_last);
  assign in_fire   = in_valid && in_ready;
  assign mux_i     = word_q;
  assign mux_s     = pos_q;

`ifdef PARAM_MUX_SEQ_MSB_FIRST_EN
  assign pos_d = pos_q - SEL_WIDTH'(1);
`else
  assign pos_d = pos_q + SEL_WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      pos_q   <= FIRST_POS;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            word_q  <= in_data;
            pos_q   <= FIRST_POS;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_fire) begin
            if (!out_last) begin
              pos_q <= pos_d;
            end else if (in_fire) begin
              word_q <= in_data;
              pos_q  <= FIRST_POS;
            end else begin
              pos_q   <= FIRST_POS;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pos_q   <= FIRST_POS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_mux_seq.sv
// Bench for param_mux_seq: queue-of-beats reference model plus directed literal expectations.
module tb_param_mux_seq;

  localparam int W = 8;
`ifdef PARAM_MUX_SEQ_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, mux_i;
  logic [2:0] mux_s;

  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_last5, busy5;
  logic [4:0] in_data5, mux_i5;
  logic [2:0] mux_s5;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [0:0] in_data1, mux_i1, mux_s1;

  param_mux_seq #(.IP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mux_i(mux_i), .mux_s(mux_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  param_mux_seq #(.IP_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .mux_i(mux_i5), .mux_s(mux_s5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_last(out_last5), .busy(busy5)
  );

  param_mux_seq #(.IP_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .mux_i(mux_i1), .mux_s(mux_s1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1)
  );

  typedef struct {
    logic       b;
    logic [2:0] sel;
    logic       last;
    logic [7:0] word;
  } beat_t;

  beat_t      mq[$];
  logic       ylog[$];
  logic [2:0] slog[$];
  logic       llog[$];
  int         clog[$];
  logic       y5log[$];
  logic [2:0] s5log[$];
  logic       l5log[$];
  logic       y1log[$];
  logic [0:0] s1log[$];
  logic       l1log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_valid_cnt = 0;
  bit acc, acc5, acc1;

  function automatic int pos_of(input int k, input int w);
    return MSB ? (w - 1 - k) : k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    ylog.delete(); slog.delete(); llog.delete(); clog.delete();
    y5log.delete(); s5log.delete(); l5log.delete();
    y1log.delete(); s1log.delete(); l1log.delete();
  endtask

  // One clock: apply inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    bit exp_rdy;
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (mq.size() == 0) || (mq.size() == 1 && ordy);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("busy", 32'(busy), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (mq.size() != 0) begin
      chk("mux_s", 32'(mux_s), 32'(mq[0].sel));
      chk("y", 32'(mux_i[mux_s]), 32'(mq[0].b));
      chk("mux_i", 32'(mux_i), 32'(mq[0].word));
      chk("out_last", 32'(out_last), 32'(mq[0].last));
    end else begin
      chk("idle_mux_s", 32'(mux_s), 32'(pos_of(0, W)));
      chk("idle_out_last", 32'(out_last), 32'd0);
    end
    if (out_valid && out_ready) begin
      ylog.push_back(mux_i[mux_s]); slog.push_back(mux_s);
      llog.push_back(out_last); clog.push_back(cyc);
      if (in_ready) rdy_valid_cnt++;
    end
    if (out_valid5) chk("sel5_range", 32'(mux_s5 <= 3'd4), 32'd1);
    chk("busy5", 32'(busy5), 32'(out_valid5));
    chk("busy1", 32'(busy1), 32'(out_valid1));
    if (out_valid5 && out_ready5) begin
      y5log.push_back(mux_i5[mux_s5]); s5log.push_back(mux_s5); l5log.push_back(out_last5);
    end
    if (out_valid1 && out_ready1) begin
      y1log.push_back(mux_i1[mux_s1]); s1log.push_back(mux_s1); l1log.push_back(out_last1);
    end
    acc  = iv && exp_rdy;
    acc5 = in_valid5 && in_ready5;
    acc1 = in_valid1 && in_ready1;
    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && ordy) void'(mq.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++) begin
          beat_t e;
          e.sel  = 3'(pos_of(k, W));
          e.b    = d[e.sel];
          e.last = (k == W - 1);
          e.word = d;
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0]  seq8;
    logic [7:0]  wrec;
    logic [15:0] seq16;
    logic [4:0]  seq5;
    logic [2:0]  seq3;
    logic [2:0]  pat1;
    logic [7:0]  pdata;
    bit          pending, rr;
    int          nl, n_acc, guard, nbefore, k1;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mux_i", 32'(mux_i), 32'd0);
    chk("rst_mux_s", 32'(mux_s), MSB ? 32'd7 : 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // 0xA5 single word, downstream always ready
    clear_logs();
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (8) step(1'b0, 1'b0, 8'h00, 1'b1);
    seq8 = '0; nl = 0;
    foreach (ylog[i]) seq8 = {seq8[6:0], ylog[i]};
    foreach (llog[i]) if (llog[i]) nl++;
    chk("a5_beats", 32'(ylog.size()), 32'd8);
    chk("a5_y_seq", 32'(seq8), 32'hA5);
    chk("a5_last_count", 32'(nl), 32'd1);
    if (slog.size() == 8) begin
      chk("a5_first_sel", 32'(slog[0]), MSB ? 32'd7 : 32'd0);
      chk("a5_last_sel", 32'(slog[7]), MSB ? 32'd0 : 32'd7);
      chk("a5_last_flag", 32'(llog[7]), 32'd1);
      for (int k = 0; k < 8; k++) chk("a5_sel_order", 32'(slog[k]), 32'(pos_of(k, 8)));
    end
    chk("a5_idle_after", 32'(out_valid), 32'd0);

    // backpressure for 3 cycles at beat 3
    clear_logs();
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("bp_hold_sel", 32'(mux_s), 32'(pos_of(3, 8)));
      chk("bp_hold_word", 32'(mux_i), 32'h3C);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
    wrec = '0;
    foreach (ylog[i]) wrec[slog[i]] = ylog[i];
    chk("bp_beats", 32'(ylog.size()), 32'd8);
    chk("bp_word", 32'(wrec), 32'h3C);
    if (slog.size() > 3) chk("bp_resume_sel", 32'(slog[3]), 32'(pos_of(3, 8)));

    // back-to-back 0x0F then 0xF0 with in_valid held
    clear_logs();
    rdy_valid_cnt = 0; n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 40) begin
      step(1'b0, 1'b1, (n_acc == 0) ? 8'h0F : 8'hF0, 1'b1);
      if (acc) n_acc++;
      guard++;
    end
    chk("b2b_accepts", 32'(n_acc), 32'd2);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);
    seq16 = '0;
    foreach (ylog[i]) seq16 = {seq16[14:0], ylog[i]};
    chk("b2b_beats", 32'(ylog.size()), 32'd16);
    chk("b2b_y_seq", 32'(seq16), MSB ? 32'h0FF0 : 32'hF00F);
    if (clog.size() == 16) chk("b2b_no_gap", 32'(clog[15] - clog[0]), 32'd15);
    chk("b2b_ready_pulses", 32'(rdy_valid_cnt), 32'd2);

    // reset in the middle of 0xFF
    clear_logs();
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rmw_pre_sel", 32'(mux_s), 32'(pos_of(4, 8)));
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("rmw_out_valid", 32'(out_valid), 32'd0);
    chk("rmw_mux_s", 32'(mux_s), MSB ? 32'd7 : 32'd0);
    chk("rmw_in_ready", 32'(in_ready), 32'd1);
    nbefore = ylog.size();
    repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rmw_no_beats", 32'(ylog.size()), 32'(nbefore));

    // randomized traffic against the model
    pending = 1'b0; pdata = '0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        pending = 1'b1;
        pdata = 8'($urandom);
      end
      step(rr, pending, pdata, $urandom_range(0, 3) != 0);
      if (acc && !rr) pending = 1'b0;
    end
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b1);

    // IP_WIDTH=5, word 0b10011
    clear_logs();
    in_valid5 = 1'b1; in_data5 = 5'b10011;
    repeat (12) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (acc5) in_valid5 = 1'b0;
    end
    seq5 = '0; nl = 0;
    foreach (y5log[i]) seq5 = {seq5[3:0], y5log[i]};
    foreach (l5log[i]) if (l5log[i]) nl++;
    chk("w5_beats", 32'(y5log.size()), 32'd5);
    chk("w5_y_seq", 32'(seq5), MSB ? 32'b10011 : 32'b11001);
    chk("w5_last_count", 32'(nl), 32'd1);
    if (s5log.size() == 5) begin
      chk("w5_first_sel", 32'(s5log[0]), MSB ? 32'd4 : 32'd0);
      chk("w5_last_flag", 32'(l5log[4]), 32'd1);
    end

    // IP_WIDTH=1, words 1,0,1 back to back
    clear_logs();
    pat1 = 3'b101; k1 = 0;
    in_valid1 = 1'b1; in_data1 = pat1[2];
    guard = 0;
    while (k1 < 3 && guard < 10) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (acc1) begin
        k1++;
        if (k1 < 3) in_data1 = pat1[2 - k1];
        else in_valid1 = 1'b0;
      end
      guard++;
    end
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    seq3 = '0; nl = 0;
    foreach (y1log[i]) seq3 = {seq3[1:0], y1log[i]};
    foreach (l1log[i]) if (l1log[i] && s1log[i] == 1'b0) nl++;
    chk("w1_beats", 32'(y1log.size()), 32'd3);
    chk("w1_y_seq", 32'(seq3), 32'b101);
    chk("w1_last_sel0", 32'(nl), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
